// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: scan/blink strobes and frame data in, digit/segment drive out.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                    tick_scan;
    logic                    tick_blink;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [7:0]              seg;
    logic                    frame_start;

    modport master (
        output tick_scan, tick_blink, digits_in, dp_in, blink_mask, blank_lz,
        input  digit_sel, seg, frame_start
    );

    modport slave (
        input  tick_scan, tick_blink, digits_in, dp_in, blink_mask, blank_lz,
        output digit_sel, seg, frame_start
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: per-digit blanking gap, frame-latched shadow data,
// leading-zero suppression and per-digit blinking.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIG_W-1:0]      sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d;
    logic                  sh_lz_q, sh_lz_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_start_q, frame_start_d;

    logic [3:0] cur_digit;
    logic       cur_dp;
    logic       cur_blink;
    logic       upper_zero;
    logic       suppress;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // Next-state, shadow latch and registered-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        sh_digits_d   = sh_digits_q;
        sh_dp_d       = sh_dp_q;
        sh_blink_d    = sh_blink_q;
        sh_lz_d       = sh_lz_q;
        blink_phase_d = blink_phase_q ^ bus.tick_blink;
        frame_start_d = 1'b0;
        digit_sel_d   = '0;
        seg_d         = '0;
        cur_digit     = 4'h0;
        cur_dp        = 1'b0;
        cur_blink     = 1'b0;
        upper_zero    = 1'b1;

        case (state_q)
            ST_BLANK: begin
                // cnt == 0 only after reset: stay dark until the first scan tick
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                end
            end
            default: ;
        endcase

        if (bus.tick_scan) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : IDX_W'(idx_q + IDX_W'(1));
            if (BLANK_CYCLES > 0) begin
                state_d = ST_BLANK;
                cnt_d   = CNT_W'(BLANK_CYCLES);
            end else begin
                state_d = ST_SHOW;
            end
            if (idx_d == '0) begin
                sh_digits_d   = bus.digits_in;
                sh_dp_d       = bus.dp_in;
                sh_blink_d    = bus.blink_mask;
                sh_lz_d       = bus.blank_lz;
                frame_start_d = 1'b1;
            end
        end

        // Select the current digit and check whether it and all higher digits are zero
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == idx_q) begin
                cur_digit = sh_digits_q[4*j +: 4];
                cur_dp    = sh_dp_q[j];
                cur_blink = sh_blink_q[j];
            end
            if (IDX_W'(j) >= idx_q && sh_digits_q[4*j +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        suppress = sh_lz_q && (idx_q != '0) && upper_zero;

        if (state_q == ST_SHOW) begin
            digit_sel_d = NUM_DIGITS'(1) << idx_q;
            if (!(blink_phase_q && cur_blink)) begin
                seg_d = {cur_dp, suppress ? 7'h00 : hex7(cur_digit)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= IDX_LAST;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blink_q    <= '0;
            sh_lz_q       <= 1'b0;
            blink_phase_q <= 1'b0;
            digit_sel_q   <= '0;
            seg_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blink_q    <= sh_blink_d;
            sh_lz_q       <= sh_lz_d;
            blink_phase_q <= blink_phase_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.digit_sel   = digit_sel_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a 4-cycle-blanking instance and a zero-blanking
// instance share one stimulus stream.
module tb_seg_scan_driver;
    localparam int unsigned ND = 8;
    localparam int unsigned BC = 4;

    typedef struct packed {
        logic [ND-1:0] sel;
        logic [7:0]    seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(ND)) bus  ();
    seg_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();

    seg_scan_driver #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    seg_scan_driver #(.NUM_DIGITS(ND), .BLANK_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    assign bus0.tick_scan  = bus.tick_scan;
    assign bus0.tick_blink = bus.tick_blink;
    assign bus0.digits_in  = bus.digits_in;
    assign bus0.dp_in      = bus.dp_in;
    assign bus0.blink_mask = bus.blink_mask;
    assign bus0.blank_lz   = bus.blank_lz;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    // Reference model state
    int          m_idx;
    logic [31:0] m_dig;
    logic [7:0]  m_dp;
    logic [7:0]  m_blink;
    logic        m_lz;
    logic        m_phase;
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int i);
        logic [3:0]  d;
        logic [6:0]  s;
        logic [31:0] hi;
        d  = m_dig[4*i +: 4];
        s  = hex_tab[d];
        hi = m_dig >> (4 * i);
        if (m_lz && i > 0 && hi == 32'h0) s = 7'h00;
        if (m_phase && m_blink[i]) return 8'h00;
        return {m_dp[i], s};
    endfunction

    task automatic model_reset();
        m_idx = ND - 1; m_dig = '0; m_dp = '0; m_blink = '0; m_lz = 1'b0; m_phase = 1'b0;
    endtask

    // Advance the model one digit, latching the frame on wrap to 0
    task automatic advance(output exp_t e, output logic fs);
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
        fs = (m_idx == 0);
        if (fs) begin
            m_dig = bus.digits_in; m_dp = bus.dp_in; m_blink = bus.blink_mask; m_lz = bus.blank_lz;
        end
        e.sel = ND'(1) << m_idx;
        e.seg = exp_seg(m_idx);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_sel"}, 32'(bus.digit_sel), 32'(e.sel));
            check({tag, "_seg"}, 32'(bus.seg), 32'(e.seg));
        end
    endtask

    task automatic scan();
        exp_t e;
        logic fs;
        advance(e, fs);
        sb.push_back(e);
        @(negedge clk) bus.tick_scan = 1'b1;
        @(posedge clk); #1 bus.tick_scan = 1'b0;
        check("frame_start", 32'(bus.frame_start), 32'(fs));
        for (int k = 1; k <= int'(BC); k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                check("nb_sel", 32'(bus0.digit_sel), 32'(e.sel));
                check("nb_seg", 32'(bus0.seg), 32'(e.seg));
                check("frame_start_end", 32'(bus.frame_start), 32'd0);
            end
            check("dark", {bus.digit_sel, bus.seg}, 32'd0);
        end
        @(posedge clk); #1;
        pop_check("digit");
        check("nb_hold", {bus0.digit_sel, bus0.seg}, {e.sel, e.seg});
        repeat (3) @(posedge clk);
    endtask

    task automatic blink_pulse();
        @(negedge clk) bus.tick_blink = 1'b1;
        @(posedge clk); #1 bus.tick_blink = 1'b0;
        m_phase = ~m_phase;
        @(posedge clk); #1;
        check("blink_sel", 32'(bus.digit_sel), 32'(ND'(1) << m_idx));
        check("blink_seg", 32'(bus.seg), 32'(exp_seg(m_idx)));
        check("blink_nb_seg", 32'(bus0.seg), 32'(exp_seg(m_idx)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        logic fs;
        bus.tick_scan = 1'b0; bus.tick_blink = 1'b0;
        bus.digits_in = '0; bus.dp_in = '0; bus.blink_mask = '0; bus.blank_lz = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", 32'(bus.digit_sel), 32'd0);
        check("rst_seg", 32'(bus.seg), 32'd0);
        check("rst_fs", 32'(bus.frame_start), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("idle_dark", {bus.digit_sel, bus.seg}, 32'd0);

        // Plain frame, then a mid-frame input change that must not tear
        bus.digits_in = 32'h8765_4321;
        for (int i = 0; i < 4; i++) scan();
        bus.digits_in = 32'h0000_0000;
        @(posedge clk); #1;
        check("no_tear_d3", 32'(bus.seg), 32'h66);
        for (int i = 4; i < 8; i++) scan();
        scan();

        // Leading-zero suppression with a decimal point on a suppressed digit
        bus.digits_in = 32'h0000_0105; bus.blank_lz = 1'b1; bus.dp_in = 8'h20;
        for (int i = 1; i < 8; i++) scan();
        for (int i = 0; i < 8; i++) scan();

        // Blinking of digit 0, mid-digit
        bus.blink_mask = 8'h01; bus.digits_in = 32'h0000_00A7; bus.blank_lz = 1'b0; bus.dp_in = '0;
        for (int i = 1; i < 8; i++) scan();
        scan();
        blink_pulse();
        blink_pulse();

        // Second tick during blanking restarts the gap; idx advances twice
        advance(e1, fs);
        advance(e2, fs);
        sb.push_back(e2);
        @(negedge clk) bus.tick_scan = 1'b1;
        @(posedge clk); #1 bus.tick_scan = 1'b0;
        @(posedge clk); #1;
        check("dbl_nb_first", {bus0.digit_sel, bus0.seg}, {e1.sel, e1.seg});
        @(negedge clk) bus.tick_scan = 1'b1;
        @(posedge clk); #1 bus.tick_scan = 1'b0;
        check("dbl_dark0", {bus.digit_sel, bus.seg}, 32'd0);
        @(posedge clk); #1;
        check("dbl_nb_second", {bus0.digit_sel, bus0.seg}, {e2.sel, e2.seg});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("dbl_dark", {bus.digit_sel, bus.seg}, 32'd0);
        end
        @(posedge clk); #1;
        pop_check("dbl");

        // Asynchronous reset while showing a digit
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(bus.digit_sel), 32'd0);
        check("arst_seg", 32'(bus.seg), 32'd0);
        check("arst_nb", {bus0.digit_sel, bus0.seg}, 32'd0);
        model_reset();
        bus.blink_mask = '0; bus.digits_in = 32'h0000_0009;
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("post_rst_dark", {bus.digit_sel, bus.seg, 7'(0), bus.frame_start}, 32'd0);
        scan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed 7-segment display driver for the simulator's dashboard readouts (speed, distance, time). Consumes the periodic scan and 1-second strobes produced by the clock generator and turns a parallel hex-digit word into one-hot digit enables plus segment patterns. It has a per-digit blanking gap against ghosting, leading-zero suppression and per-digit blinking, and it latches the input once per frame to prevent tearing.

## Interface
- NUM_DIGITS, 8: number of digits scanned; valid range 2–8.
- BLANK_CYCLES, 4: clocks with all outputs off after each digit change; valid range 0–255.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous reset, active-low. Fixed decision: one clock; reset is asynchronous and active-low.
- tick_scan  in  1  one-clock strobe, about every 1 ms; advances the digit.
- tick_blink  in  1  one-clock strobe, every 1 s; toggles the blink phase.
- digits_in  in  4*NUM_DIGITS  hex digits; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blink_mask  in  NUM_DIGITS  digits that blink.
- blank_lz  in  1  enables leading-zero suppression.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high.
- seg  out  8  segment outputs, active-high; seg[0]=a … seg[6]=g, seg[7]=dp.
- frame_start  out  1  one-clock pulse when the shadow registers load.

## Operation
- Digit index idx runs 0..NUM_DIGITS-1. After reset, idx = NUM_DIGITS-1, so the first tick_scan selects digit 0.
- FSM has two states, BLANK and SHOW. Reset state is BLANK with the counter at 0. The FSM stays idle-dark until the first tick_scan.
- A tick_scan in either state does the following:
  - idx advances; NUM_DIGITS-1 wraps to 0.
  - If BLANK_CYCLES > 0, the FSM enters BLANK with cnt = BLANK_CYCLES.
  - If BLANK_CYCLES = 0, the FSM enters SHOW directly.
- In BLANK, cnt decrements each clock. When cnt reaches 1 (the BLANK_CYCLES-th clock), the FSM moves to SHOW.
- A tick_scan arriving during BLANK restarts blanking for the next idx.
- Frame latch: on the tick that moves idx to 0, the shadow registers capture digits_in, dp_in, blink_mask and blank_lz, and frame_start pulses. All decode in that frame uses the shadow values only.
- Hex decode of seg[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- seg[7] = shadow dp of idx.
- Leading-zero rule: digit i (i ≥ 1) is suppressed when blank_lz is set and every shadow digit j ≥ i is 0.
  - Suppression forces seg[6:0] = 0 and keeps dp.
  - Digit 0 is never suppressed.
- Blink: blink_phase resets to 0 and toggles on each tick_blink. While blink_phase = 1, digits with the mask bit set drive seg = 00, including dp. digit_sel still pulses for those digits.
- Outputs in SHOW: digit_sel = 1 << idx and seg = the decoded value.
- Outputs in BLANK: digit_sel = 0 and seg = 0.

## Timing
- All outputs are registered.
- Reset values: digit_sel = 0, seg = 0, frame_start = 0, blink_phase = 0, idx = NUM_DIGITS-1, shadow registers = 0.
- tick_scan sampled at edge T:
  - Outputs are 0 from T+1 through T+BLANK_CYCLES.
  - The new digit appears at edge T+BLANK_CYCLES+1.
  - With BLANK_CYCLES = 0, the new digit appears at T+1.
- frame_start is high for exactly the clock after edge T when idx goes to 0.
- Segment data always reflects the current shadow values: there is no mid-frame change even if digits_in changes.
- tick_blink takes effect from the next clock, including mid-digit.
- tick_scan and tick_blink in the same clock are both applied independently.
- Assertion of rst_n mid-frame immediately forces all outputs to reset values, asynchronously. After release, operation resumes only on the next tick_scan, starting at digit 0.

## Test plan
- Reset, NUM_DIGITS=8, BLANK_CYCLES=4, digits_in=32'h8765_4321, 8 tick_scans 1000 clocks apart:
  - digit_sel = 01,02,…,80 in order.
  - seg = 06,5B,4F,66,6D,7D,07,7F.
  - Each digit appears exactly 5 clocks after its tick, with 4 dark clocks before it.
  - frame_start pulses once, on the first tick.
- Change digits_in to 32'h0000_0000 while digit 3 is displayed: remaining digits of the frame still show the old values; the new value appears after the next wrap to digit 0.
- blank_lz=1, digits_in=32'h0000_0105:
  - digits 7..3 show seg = 00.
  - digit 2 shows 06, digit 1 shows 3F (embedded zero not suppressed), digit 0 shows 6D.
  - dp_in bit 5 set still drives seg = 80 on digit 5.
- blink_mask=8'h01, one tick_blink: digit 0 shows seg = 00 with digit_sel = 01; a second tick_blink restores the decoded pattern.
- BLANK_CYCLES=0: new digit at T+1, with no all-zero clock between digits. Two tick_scans 2 clocks apart with BLANK_CYCLES=4: the second restarts blanking, and idx advances twice.
- Assert rst_n low while in SHOW: digit_sel = 0 and seg = 0 immediately, without waiting for an edge. After release with no tick, outputs stay 0; the first tick selects digit 0 and pulses frame_start.
